// File: rtl/ppm_tx_if.sv
// Word handshake and transmit status bundle between the link-layer framers and ppm_tx_scheduler.
interface ppm_tx_if #(
   parameter int WORD_W = 32
);
   logic [1:0]        req_valid;
   logic [WORD_W-1:0] req_data0;
   logic [WORD_W-1:0] req_data1;
   logic [1:0]        req_ready;
   logic              grant_id;
   logic              busy;
   logic              pulse_out;
   logic              word_done;

   modport master (
      output req_valid, req_data0, req_data1,
      input  req_ready, grant_id, busy, pulse_out, word_done
   );

   modport slave (
      input  req_valid, req_data0, req_data1,
      output req_ready, grant_id, busy, pulse_out, word_done
   );
endinterface

// File: rtl/ppm_tx_scheduler.sv
// PPM transmit scheduler: round-robin word arbitration, MSB-first N-bit symbol serialization.
// Optional preamble compiled in with `define PPM_TX_PREAMBLE_EN.
module ppm_tx_scheduler #(
   parameter int N       = 4,
   parameter int L       = 4,
   parameter int WORD_W  = 32,
   parameter int PRE_LEN = 4
) (
   input  logic clk,
   input  logic rst_n,
   ppm_tx_if.slave bus
);

   localparam int SYMS    = WORD_W / N;
   localparam int SYM_MAX = (SYMS > PRE_LEN) ? SYMS : PRE_LEN;
   localparam int SYM_W   = (SYM_MAX > 1) ? $clog2(SYM_MAX) : 1;
   localparam int CYC_W   = (L > 1) ? $clog2(L) : 1;

   localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SYMS - 1);
   localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(L - 1);

`ifdef PPM_TX_PREAMBLE_EN
   typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PRE = 2'd2} state_t;
   localparam state_t START_ST = PRE;
   localparam logic [SYM_W-1:0] PRE_LAST = SYM_W'(PRE_LEN - 1);
`else
   typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1} state_t;
   localparam state_t START_ST = DATA;
`endif

   state_t            state, nxt_state;
   logic [CYC_W-1:0]  cyc, nxt_cyc;
   logic [N-1:0]      slot, nxt_slot;
   logic [SYM_W-1:0]  sym, nxt_sym;
   logic [WORD_W-1:0] sh, nxt_sh;
   logic [N-1:0]      nxt_val;
   logic              last_grant, gnt_sel, grant_q, pulse_q;
   logic [1:0]        ready;
   logic              sym_end, word_end, accept_win, accept;

   assign sym_end    = (cyc == CYC_LAST) && (&slot);
   assign word_end   = (state == DATA) && sym_end && (sym == SYM_LAST);
   assign accept_win = (state == IDLE) || word_end;
   assign accept     = |(bus.req_valid & ready);

   assign bus.req_ready = ready;
   assign bus.word_done = word_end;
   assign bus.busy      = (state != IDLE);
   assign bus.grant_id  = grant_q;
   assign bus.pulse_out = pulse_q;

   // Round-robin: on a tie the requester that did not win last time is served.
   always_comb begin
      ready   = 2'b00;
      gnt_sel = 1'b0;
      if (accept_win) begin
         case (bus.req_valid)
            2'b01: begin gnt_sel = 1'b0; ready = 2'b01; end
            2'b10: begin gnt_sel = 1'b1; ready = 2'b10; end
            2'b11: begin
               gnt_sel = ~last_grant;
               ready   = gnt_sel ? 2'b10 : 2'b01;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      nxt_state = state;
      nxt_cyc   = cyc;
      nxt_slot  = slot;
      nxt_sym   = sym;
      nxt_sh    = sh;
      if (accept) begin
         nxt_state = START_ST;
         nxt_cyc   = '0;
         nxt_slot  = '0;
         nxt_sym   = '0;
         nxt_sh    = gnt_sel ? bus.req_data1 : bus.req_data0;
      end else if (state != IDLE) begin
         if (cyc == CYC_LAST) begin
            nxt_cyc  = '0;
            nxt_slot = slot + 1'b1;
         end else begin
            nxt_cyc  = cyc + 1'b1;
         end
         if (sym_end) begin
            nxt_sym = sym + 1'b1;
`ifdef PPM_TX_PREAMBLE_EN
            if (state == PRE) begin
               if (sym == PRE_LAST) begin
                  nxt_state = DATA;
                  nxt_sym   = '0;
               end
            end else
`endif
            begin
               nxt_sh = sh << N;
               if (sym == SYM_LAST) begin
                  nxt_state = IDLE;
                  nxt_sym   = '0;
                  nxt_sh    = '0;
               end
            end
         end
      end
   end

   // Symbol value for the cycle being entered; pulse_out is registered from it.
   always_comb begin
`ifdef PPM_TX_PREAMBLE_EN
      if (nxt_state == PRE) nxt_val = {N{~nxt_sym[0]}};
      else                  nxt_val = nxt_sh[WORD_W-1 -: N];
`else
      nxt_val = nxt_sh[WORD_W-1 -: N];
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cyc        <= '0;
         slot       <= '0;
         sym        <= '0;
         sh         <= '0;
         pulse_q    <= 1'b0;
         grant_q    <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         state   <= nxt_state;
         cyc     <= nxt_cyc;
         slot    <= nxt_slot;
         sym     <= nxt_sym;
         sh      <= nxt_sh;
         pulse_q <= (nxt_state != IDLE) && (nxt_slot == nxt_val);
         if (accept) begin
            grant_q    <= gnt_sel;
            last_grant <= gnt_sel;
         end
      end
   end

endmodule

// File: tb/tb_ppm_tx_scheduler.sv
// Directed bench for ppm_tx_scheduler with N=2, L=2, WORD_W=8, PRE_LEN=2 (S=8).
module tb_ppm_tx_scheduler;

`ifdef PPM_TX_PREAMBLE_EN
   localparam int TOT = 48;
`else
   localparam int TOT = 32;
`endif

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   ppm_tx_if #(.WORD_W(8)) bus ();

   ppm_tx_scheduler #(.N(2), .L(2), .WORD_W(8), .PRE_LEN(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  valid;
      logic [7:0]  d0;
      logic [7:0]  d1;
      logic [1:0]  rdy;
      logic        gid;
      logic [31:0] mask;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", nm, got, exp);
      end
   endtask

   // Data-symbol pulse bitmap, prefixed by the preamble (3,0 -> offsets 6-7, 8-9) when compiled in.
   function automatic logic [TOT-1:0] full_mask(input logic [31:0] d);
`ifdef PPM_TX_PREAMBLE_EN
      return {d, 16'h03C0};
`else
      return d;
`endif
   endfunction

   task automatic do_reset();
      @(negedge clk);
      bus.req_valid = 2'b00;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Called just after an accept edge; returns at the word_done cycle (after sampling).
   task automatic watch_word(input logic [TOT-1:0] mask, input logic gid, input logic [1:0] rdy_done,
                             input logic [1:0] v_during, input int drop_at, input string tag);
      for (int o = 0; o < TOT; o++) begin
         @(negedge clk);
         if (o == 0) bus.req_valid = v_during;
         if (o == drop_at) bus.req_valid = 2'b00;
         #1;
         chk($sformatf("%s pulse@%0d", tag, o), 64'(bus.pulse_out), 64'(mask[o]));
         chk($sformatf("%s busy@%0d", tag, o), 64'(bus.busy), 64'd1);
         chk($sformatf("%s word_done@%0d", tag, o), 64'(bus.word_done), 64'(o == TOT-1));
         chk($sformatf("%s req_ready@%0d", tag, o), 64'(bus.req_ready),
             64'((o == TOT-1) ? rdy_done : 2'b00));
         chk($sformatf("%s grant_id@%0d", tag, o), 64'(bus.grant_id), 64'(gid));
      end
   endtask

   task automatic start_word(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                             input logic [1:0] rdy, input string tag);
      @(negedge clk);
      bus.req_valid = v;
      bus.req_data0 = d0;
      bus.req_data1 = d1;
      #1;
      chk({tag, " idle req_ready"}, 64'(bus.req_ready), 64'(rdy));
      chk({tag, " idle busy"}, 64'(bus.busy), 64'd0);
      @(posedge clk);
   endtask

   task automatic expect_idle(input string tag);
      @(negedge clk);
      #1;
      chk({tag, " end busy"}, 64'(bus.busy), 64'd0);
      chk({tag, " end pulse"}, 64'(bus.pulse_out), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int wd_cnt, busy_cnt, pulse_cnt;
      bus.req_valid = 2'b00;
      bus.req_data0 = 8'h00;
      bus.req_data1 = 8'h00;
      rst_n = 1'b0;

      // Hand-computed maps: symbol k of value v pulses bits 8k+2v and 8k+2v+1.
      vecs[0] = '{2'b01, 8'hB4, 8'h00, 2'b01, 1'b0, 32'h030CC030};
      vecs[1] = '{2'b10, 8'h00, 8'h1B, 2'b10, 1'b1, 32'hC0300C03};
      vecs[2] = '{2'b11, 8'hE4, 8'hFF, 2'b01, 1'b0, 32'h030C30C0};
      vecs[3] = '{2'b11, 8'h00, 8'hFF, 2'b10, 1'b1, 32'hC0C0C0C0};
      vecs[4] = '{2'b01, 8'h00, 8'h00, 2'b01, 1'b0, 32'h03030303};

      repeat (2) @(negedge clk);
      #1;
      chk("reset busy", 64'(bus.busy), 64'd0);
      chk("reset pulse", 64'(bus.pulse_out), 64'd0);
      chk("reset word_done", 64'(bus.word_done), 64'd0);
      chk("reset grant_id", 64'(bus.grant_id), 64'd0);
      chk("reset req_ready", 64'(bus.req_ready), 64'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) begin
         start_word(vecs[i].valid, vecs[i].d0, vecs[i].d1, vecs[i].rdy, $sformatf("vec%0d", i));
         watch_word(full_mask(vecs[i].mask), vecs[i].gid, 2'b00, 2'b00, -1, $sformatf("vec%0d", i));
         expect_idle($sformatf("vec%0d", i));
      end

      // Both valid from reset: 00 from requester 0, then FF from requester 1 with no gap.
      do_reset();
      start_word(2'b11, 8'h00, 8'hFF, 2'b01, "b2b");
      watch_word(full_mask(32'h03030303), 1'b0, 2'b10, 2'b11, -1, "b2b w0");
      watch_word(full_mask(32'hC0C0C0C0), 1'b1, 2'b00, 2'b00, -1, "b2b w1");
      expect_idle("b2b");

      // Requester 1 held valid while requester 0 keeps offering: grants alternate.
      do_reset();
      start_word(2'b11, 8'hB4, 8'h1B, 2'b01, "alt");
      watch_word(full_mask(32'h030CC030), 1'b0, 2'b10, 2'b11, -1, "alt w0");
      watch_word(full_mask(32'hC0300C03), 1'b1, 2'b01, 2'b11, -1, "alt w1");
      watch_word(full_mask(32'h030CC030), 1'b0, 2'b10, 2'b11, -1, "alt w2");
      watch_word(full_mask(32'hC0300C03), 1'b1, 2'b00, 2'b00, -1, "alt w3");
      expect_idle("alt");

      // Reset at offset 13 of a word, then a fresh word from requester 1.
      do_reset();
      start_word(2'b01, 8'hB4, 8'h00, 2'b01, "mrst");
      for (int o = 0; o <= 13; o++) begin
         @(negedge clk);
         bus.req_valid = 2'b00;
      end
      rst_n = 1'b0;
      #1;
      chk("mrst pulse", 64'(bus.pulse_out), 64'd0);
      chk("mrst busy", 64'(bus.busy), 64'd0);
      chk("mrst word_done", 64'(bus.word_done), 64'd0);
      chk("mrst grant_id", 64'(bus.grant_id), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      wd_cnt = 0; busy_cnt = 0; pulse_cnt = 0;
      for (int o = 0; o < 2*TOT; o++) begin
         @(negedge clk);
         #1;
         if (bus.word_done) wd_cnt++;
         if (bus.busy) busy_cnt++;
         if (bus.pulse_out) pulse_cnt++;
      end
      chk("mrst stray word_done", 64'(wd_cnt), 64'd0);
      chk("mrst stray busy", 64'(busy_cnt), 64'd0);
      chk("mrst stray pulse", 64'(pulse_cnt), 64'd0);
      start_word(2'b10, 8'h00, 8'hE4, 2'b10, "mrst new");
      watch_word(full_mask(32'h030C30C0), 1'b1, 2'b00, 2'b00, -1, "mrst new");
      expect_idle("mrst new");

      // Requester 1 raises then drops valid while busy: never granted.
      do_reset();
      start_word(2'b01, 8'h1B, 8'hFF, 2'b01, "drop");
      watch_word(full_mask(32'hC0300C03), 1'b0, 2'b00, 2'b10, 20, "drop");
      expect_idle("drop");
      chk("drop grant_id", 64'(bus.grant_id), 64'd0);
      chk("drop req_ready", 64'(bus.req_ready), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
